// File: rtl/reg_file_multi_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : reg_file_multi_if                                         |
// | Brief  : Bus bundle for reg_file_multi: read/write ports, sweep    |
// |          control and the LED debug view.                           |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
interface reg_file_multi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NB    = DATA_W / 8;
  localparam int OPT_W = (NB > 1) ? $clog2(NB) : 1;

  logic [ADDR_W-1:0] R_Addr_A;
  logic [ADDR_W-1:0] R_Addr_B;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic              Write_Reg;
  logic [NB-1:0]     Byte_En;
  logic              Clear_Req;
  logic              Busy;
  logic [DATA_W-1:0] R_Data_A;
  logic [DATA_W-1:0] R_Data_B;
  logic              A_B;
  logic [OPT_W-1:0]  Opt;
  logic [7:0]        LED;

  modport master (
    output R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, Byte_En,
           Clear_Req, A_B, Opt,
    input  Busy, R_Data_A, R_Data_B, LED
  );

  modport slave (
    input  R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, Byte_En,
           Clear_Req, A_B, Opt,
    output Busy, R_Data_A, R_Data_B, LED
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_multi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : reg_file_multi                                            |
// | Brief  : Parametrised 2-read/1-write register file with byte       |
// |          enables, optional bypass / registered reads, hardwired    |
// |          zero register, soft-clear sweep and LED debug byte.       |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module reg_file_multi #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  reg_file_multi_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam int OPT_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state;
  logic              busy;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_accept;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] led_src;
  logic [7:0]        led_next;
  logic [7:0]        led;

  // Write qualification and byte-merged write word (unchanged when Byte_En is zero)
  always_comb begin
    wr_accept = bus.Write_Reg && !busy &&
                !((ZERO_REG != 0) && (bus.W_Addr == '0));
    wr_merged = mem[bus.W_Addr];
    for (int i = 0; i < NB; i++) begin
      if (bus.Byte_En[i]) begin
        wr_merged[8*i +: 8] = bus.W_Data[8*i +: 8];
      end
    end
  end

  // Read value per port: zero register wins, then forwarded write, then array
  always_comb begin
    val_a = mem[bus.R_Addr_A];
    val_b = mem[bus.R_Addr_B];
    if ((BYPASS != 0) && wr_accept && (bus.W_Addr == bus.R_Addr_A)) begin
      val_a = wr_merged;
    end
    if ((BYPASS != 0) && wr_accept && (bus.W_Addr == bus.R_Addr_B)) begin
      val_b = wr_merged;
    end
    if ((ZERO_REG != 0) && (bus.R_Addr_A == '0)) begin
      val_a = '0;
    end
    if ((ZERO_REG != 0) && (bus.R_Addr_B == '0)) begin
      val_b = '0;
    end
  end

  // Array storage and soft-clear sweep FSM; writes are only taken while idle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (wr_accept) begin
            mem[bus.W_Addr] <= wr_merged;
          end
          if (bus.Clear_Req) begin
            state <= SWEEP;
            busy  <= 1'b1;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          mem[ptr] <= '0;
          // Explicit terminal compare on the last register of the array
          if (ptr == {ADDR_W{1'b1}}) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ptr   <= '0;
        end
      endcase
    end
  end

  generate
    if (READ_LAT != 0) begin : g_rd_reg
      // Registered read data; without bypass this captures pre-write content
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          rd_a <= '0;
          rd_b <= '0;
        end else begin
          rd_a <= val_a;
          rd_b <= val_b;
        end
      end
    end else begin : g_rd_comb
      // Combinational read data straight from the read-value mux
      always_comb begin
        rd_a = val_a;
        rd_b = val_b;
      end
    end
  endgenerate

  // LED byte select; out-of-range selects produce zero
  always_comb begin
    led_src  = bus.A_B ? rd_b : rd_a;
    led_next = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (bus.Opt == OPT_W'(i)) begin
        led_next = led_src[8*i +: 8];
      end
    end
  end

  // Registered debug byte, one cycle behind the read data it views
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      led <= 8'h00;
    end else begin
      led <= led_next;
    end
  end

  assign bus.Busy     = busy;
  assign bus.R_Data_A = rd_a;
  assign bus.R_Data_B = rd_b;
  assign bus.LED      = led;
endmodule
`default_nettype wire

// File: doc/reg_file_multi.md
Name: reg_file_multi

Overview:
Parametrised successor to the lab register file.
- Generalises data width and depth.
- Two asynchronous-address read ports (A, B) and one write port with per-byte enables.
- Optional write-to-read bypass, optional registered reads, hardwired-zero register 0.
- Multi-cycle soft-clear sweep FSM with a busy flag.
- Registered 8-bit LED debug view selects one byte of port A or B. Sits in the datapath between instruction decode and ALU.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8, ≥8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port.
- READ_LAT, 0, 0 = combinational read data, 1 = read data registered on Clk.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- R_Addr_A  in  ADDR_W  read address, port A.
- R_Addr_B  in  ADDR_W  read address, port B.
- W_Addr  in  ADDR_W  write address.
- W_Data  in  DATA_W  write data.
- Write_Reg  in  1  write strobe.
- Byte_En  in  DATA_W/8  per-byte write enable, bit i covers W_Data[8i+7:8i].
- Clear_Req  in  1  start soft-clear sweep.
- Busy  out  1  sweep in progress.
- R_Data_A  out  DATA_W  read data, port A.
- R_Data_B  out  DATA_W  read data, port B.
- A_B  in  1  LED source: 0 = port A, 1 = port B.
- Opt  in  max(1,clog2(DATA_W/8))  LED byte select.
- LED  out  8  registered debug byte.

Behaviour:
- Reset (async, active-high): all DEPTH registers = 0, Busy = 0, FSM = IDLE, sweep pointer = 0, LED = 0, registered R_Data_* = 0.
- Write accept, at posedge Clk: Write_Reg=1 and Busy=0 and not (ZERO_REG=1 and W_Addr=0).
  - Each byte i with Byte_En[i]=1 takes W_Data byte i; other bytes hold.
  - Byte_En all-zero = no change.
- Read value V(addr):
  - 0 if ZERO_REG=1 and addr=0.
  - Otherwise, if BYPASS=1 and a write is accepted this cycle with W_Addr=addr: array bytes merged with enabled W_Data bytes.
  - Otherwise the array content.
- READ_LAT=0: R_Data_x = V(R_Addr_x) combinationally.
- READ_LAT=1: R_Data_x <= V(R_Addr_x) at each posedge. With BYPASS=0 the registered value is the pre-write content.
- Both ports may read the same address; no read-read conflict.
- Soft-clear FSM, states IDLE and SWEEP:
  - IDLE: Clear_Req=1 at posedge -> SWEEP, ptr <= 0, Busy <= 1. A write presented in that same cycle is still accepted (Busy was 0).
  - SWEEP: each posedge reg[ptr] <= 0, ptr <= ptr+1. One register per cycle, DEPTH cycles total.
  - At ptr = DEPTH-1: clear it, -> IDLE, Busy <= 0. Busy is high for exactly DEPTH cycles.
  - Clear_Req during SWEEP is ignored; no restart.
  - Writes during Busy=1 are dropped silently; no bypass either.
  - Reads during SWEEP are allowed and return current, partially cleared contents.
  - Reset mid-sweep: immediate full clear, IDLE, Busy=0.
- LED: each posedge LED <= byte Opt of (A_B ? R_Data_B : R_Data_A).
  - LED latency is 1 cycle after R_Data, so 2 cycles from address when READ_LAT=1.
  - Opt >= DATA_W/8 -> LED <= 0.
- Arithmetic: the sweep pointer is ADDR_W bits wide, with an explicit terminal compare (no reliance on wrap).

Test Plan:
- Reset, write R1 = 0x12345678 (Byte_En=4'hF), then A_B=0, R_Addr_A=1, Opt=0..3 -> R_Data_A=0x12345678; LED=0x78, 0x56, 0x34, 0x12 on successive cycles.
- Byte-enable merge: R2=0xAAAAAAAA, then write 0x00001155 with Byte_En=4'b0011 -> R2=0xAAAA1155; Byte_En=0 write -> unchanged.
- Zero register: write 0xFFFFFFFF to R0 -> both ports read 0. With ZERO_REG=0 build -> reads 0xFFFFFFFF.
- Bypass:
  - BYPASS=1, READ_LAT=0: write R3=0xDEADBEEF while R_Addr_B=3 -> R_Data_B=0xDEADBEEF in the same cycle.
  - BYPASS=0, READ_LAT=1: registered value is the old R3 and shows the new value one cycle later.
- Soft clear:
  - Fill R1..R31 with nonzero values, pulse Clear_Req -> Busy high exactly 32 cycles.
  - Write to R5 at sweep cycle 10 is dropped.
  - After Busy falls, all reads return 0.
  - Clear_Req pulsed mid-sweep does not extend Busy.
- Reset mid-sweep at cycle 7: Busy=0 and LED=0 immediately (no clock edge); all registers 0; the next write accepted normally.
